dma_ctrl: RTL and testbench

- Block-copy engine that shares the 16-bit address / 8-bit data memory bus with the 8-bit CPU.
- On `start` it requests the bus from the CPU controller with `hold`, and waits for grant `hlda`. The CPU controller grants only at an instruction boundary.
- Once granted, it copies `len` bytes from `src_addr` to `dst_addr`, one read cycle and one write cycle per byte. It then releases the bus and pulses `done`.
- It sits beside `control`; its bus outputs are tri-stated and merged onto the shared memory bus.

---
 rtl/dma_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dma_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dma_ctrl
// Description : Block-copy DMA engine sharing the CPU memory bus. Requests the
//               bus with hold, waits for hlda, then copies len bytes from
//               src_addr to dst_addr (one read + one write cycle per byte),
//               releases the bus and pulses done.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               start            - one-cycle copy request (ignored while busy)
//               src_addr/dst_addr/len - copy descriptor, sampled on start
//               hlda             - bus grant from the CPU controller
//               data_in          - read data, valid the cycle after read
//               hold             - bus request
//               addr, data_out   - tri-stated bus outputs
//               read, write      - memory strobes
//               busy, done, cnt  - status: not idle, completion pulse,
//                                  bytes remaining
// Revision    : 1.0 - initial release
// ============================================================================
module dma_ctrl #(
    parameter int AW = 16,
    parameter int DW = 8,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    input  logic          hlda,
    input  logic [DW-1:0] data_in,
    output logic          hold,
    output wire  [AW-1:0] addr,
    output wire  [DW-1:0] data_out,
    output logic          read,
    output logic          write,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_LAT  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam logic [AW-1:0] C_ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] C_CNT_ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] C_CNT_ZERO = {LW{1'b0}};

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [LW-1:0] r_cnt;
    logic [DW-1:0] r_buf;

    logic w_hold;
    logic w_read;
    logic w_write;
    logic w_busy;
    logic w_done;

    // State register plus datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_src   <= {AW{1'b0}};
            r_dst   <= {AW{1'b0}};
            r_cnt   <= C_CNT_ZERO;
            r_buf   <= {DW{1'b0}};
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src <= src_addr;
                        r_dst <= dst_addr;
                        r_cnt <= len;
                    end
                end
                S_LAT: begin
                    r_buf <= data_in;
                end
                S_WR: begin
                    // Addresses wrap naturally modulo 2^AW
                    r_src <= r_src + C_ADDR_ONE;
                    r_dst <= r_dst + C_ADDR_ONE;
                    r_cnt <= r_cnt - C_CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (len == C_CNT_ZERO) ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                if (hlda) begin
                    w_next = S_RD;
                end
            end
            S_RD:  w_next = S_LAT;
            S_LAT: w_next = S_WR;
            S_WR: begin
                // A grant lost mid-byte only takes effect here, after the
                // byte is fully written; hold stays high while re-requesting.
                if (r_cnt == C_CNT_ONE) begin
                    w_next = S_FIN;
                end else if (hlda) begin
                    w_next = S_RD;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        w_hold  = 1'b0;
        w_read  = 1'b0;
        w_write = 1'b0;
        w_busy  = (r_state != S_IDLE);
        w_done  = 1'b0;
        case (r_state)
            S_REQ: w_hold = 1'b1;
            S_RD: begin
                w_hold = 1'b1;
                w_read = 1'b1;
            end
            S_LAT: w_hold = 1'b1;
            S_WR: begin
                w_hold  = 1'b1;
                w_write = 1'b1;
            end
            S_FIN:   w_done = 1'b1;
            default: ;
        endcase
    end

    assign hold  = w_hold;
    assign read  = w_read;
    assign write = w_write;
    assign busy  = w_busy;
    assign done  = w_done;
    assign cnt   = r_cnt;

    // Bus drivers release the shared bus whenever no strobe is active
    assign addr     = w_read  ? r_src :
                      w_write ? r_dst : {AW{1'bz}};
    assign data_out = w_write ? r_buf : {DW{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_ctrl
// Description : Self-checking bench for dma_ctrl. A bus model serves reads and
//               commits writes to a memory array; a scoreboard of expected
//               read addresses and write address/data pairs is filled when a
//               copy is launched and drained as the DUT strobes the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [7:0]  len;
    logic        hlda;
    logic [7:0]  data_in;
    logic        hold;
    wire  [15:0] addr;
    wire  [7:0]  data_out;
    logic        read;
    logic        write;
    logic        busy;
    logic        done;
    logic [7:0]  cnt;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  mdl [0:65535];
    logic [15:0] exp_rd [$];
    logic [23:0] exp_wr [$];

    always #5 clk = ~clk;

    dma_ctrl #(.AW(16), .DW(8), .LW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .hlda     (hlda),
        .data_in  (data_in),
        .hold     (hold),
        .addr     (addr),
        .data_out (data_out),
        .read     (read),
        .write    (write),
        .busy     (busy),
        .done     (done),
        .cnt      (cnt)
    );

    // Bus model and scoreboard: compares each strobe against the queues
    always @(posedge clk) begin
        if (read && write) begin
            checks++;
            errors++;
            $display("FAIL strobe_overlap: read=%0b write=%0b, required not both 1", read, write);
        end
        if (read) begin
            rd_cnt++;
            checks++;
            if (exp_rd.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: addr=%h, required no read", addr);
            end else begin
                logic [15:0] e;
                e = exp_rd.pop_front();
                if (addr !== e) begin
                    errors++;
                    $display("FAIL read_addr: got %h, required %h", addr, e);
                end
            end
            data_in <= mem[addr];
        end
        if (write) begin
            wr_cnt++;
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", addr, data_out);
            end else begin
                logic [23:0] e;
                e = exp_wr.pop_front();
                if ({addr, data_out} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             addr, data_out, e[23:8], e[7:0]);
                end
            end
            mem[addr] = data_out;
        end
        if (done) done_cnt++;
    end

    function automatic logic [7:0] pat(int i);
        return 8'((i * 37 + 11) ^ (i >> 8));
    endfunction

    // Pushes the expected bus traffic of a copy, updating the memory model
    // byte by byte so overlapping ranges are modelled in ascending order.
    function automatic void push_exp(logic [15:0] s, logic [15:0] d, int nrd, int nwr);
        for (int i = 0; i < nrd; i++) exp_rd.push_back(16'(s + i));
        for (int i = 0; i < nwr; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            logic [7:0]  v;
            a = 16'(s + i);
            b = 16'(d + i);
            v = mdl[a];
            mdl[b] = v;
            exp_wr.push_back({b, v});
        end
    endfunction

    // Called at a negedge; returns at the negedge of the cycle after start.
    task automatic do_start(logic [15:0] s, logic [15:0] d, logic [7:0] n);
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Steps negedges (cycle 1 = current) until done; -1 on timeout.
    task automatic run_to_done(output int cyc_done, output int cyc_rd, output int hold_cyc);
        cyc_done = -1;
        cyc_rd   = -1;
        hold_cyc = 0;
        for (int c = 1; c <= 400; c++) begin
            if (read && cyc_rd < 0) cyc_rd = c;
            if (hold) hold_cyc++;
            if (done) begin
                cyc_done = c;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; hlda = 1'b1;
        src_addr = '0; dst_addr = '0; len = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({hold, read, write, busy, done} !== 5'b0 || cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: hold/read/write/busy/done=%b cnt=%0d, required 00000 cnt=0",
                     {hold, read, write, busy, done}, cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_copy;
        int cd, cr, hc, r0, w0, d0;
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        hlda = 1'b1;
        push_exp(16'h0010, 16'h0080, 3, 3);
        do_start(16'h0010, 16'h0080, 8'd3);
        run_to_done(cd, cr, hc);
        checks++;
        if (cd != 11) begin
            errors++; $display("FAIL basic_done_cycle: got %0d, required 11", cd);
        end
        checks++;
        if (cr != 2) begin
            errors++; $display("FAIL basic_first_read: got %0d, required 2", cr);
        end
        checks++;
        if (rd_cnt - r0 != 3 || wr_cnt - w0 != 3) begin
            errors++; $display("FAIL basic_pulses: reads=%0d writes=%0d, required 3/3", rd_cnt - r0, wr_cnt - w0);
        end
        checks++;
        if (cnt !== 8'd0 || busy !== 1'b0 || read !== 1'b0 || write !== 1'b0) begin
            errors++; $display("FAIL basic_end_state: cnt=%0d busy=%b rd=%b wr=%b, required 0/0/0/0", cnt, busy, read, write);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL basic_done_count: got %0d, required 1", done_cnt - d0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[16'h0080 + i] !== mem[16'h0010 + i]) begin
                errors++; $display("FAIL basic_data[%0d]: got %h, required %h", i, mem[16'h0080 + i], mem[16'h0010 + i]);
            end
        end
    endtask

    task automatic test_len_zero;
        int cd, cr, hc, r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        do_start(16'h0200, 16'h0300, 8'd0);
        run_to_done(cd, cr, hc);
        checks++;
        if (cd != 1) begin
            errors++; $display("FAIL zero_done_cycle: got %0d, required 1", cd);
        end
        checks++;
        if (hc != 0 || rd_cnt != r0 || wr_cnt != w0) begin
            errors++; $display("FAIL zero_bus_quiet: hold_cycles=%0d reads=%0d writes=%0d, required 0/0/0",
                               hc, rd_cnt - r0, wr_cnt - w0);
        end
    endtask

    task automatic test_grant_control;
        int cd, cr, hc, nr;
        bit seen_hold, early_read, quiet_ok;
        hlda = 1'b0;
        push_exp(16'h0400, 16'h0500, 4, 4);
        do_start(16'h0400, 16'h0500, 8'd4);
        seen_hold = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (hold) begin seen_hold = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen_hold) begin
            errors++; $display("FAIL grant_hold_rise: hold=%b, required 1", hold);
        end
        early_read = 1'b0;
        repeat (5) begin
            if (read || write) early_read = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (early_read) begin
            errors++; $display("FAIL grant_wait: bus strobed before grant, required no strobe");
        end
        hlda = 1'b1;
        nr = 0;
        for (int c = 0; c < 50; c++) begin
            if (read) nr++;
            if (nr == 2) break;
            @(negedge clk);
        end
        hlda = 1'b0;              // drop grant during RD of byte 2
        repeat (3) @(negedge clk); // LAT, WR, then back in REQ
        quiet_ok = 1'b1;
        repeat (6) begin
            if (hold !== 1'b1 || read || write) quiet_ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!quiet_ok || wr_cnt == 0) begin
            errors++; $display("FAIL grant_regrant_wait: hold=%b rd=%b wr=%b, required hold=1 and bus quiet", hold, read, write);
        end
        hlda = 1'b1;
        run_to_done(cd, cr, hc);
        checks++;
        if (cd < 0 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
            errors++; $display("FAIL grant_complete: done_cycle=%0d pending rd=%0d wr=%0d, required done and 0/0",
                               cd, exp_rd.size(), exp_wr.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[16'h0500 + i] !== mdl[16'h0500 + i]) begin
                errors++; $display("FAIL grant_data[%0d]: got %h, required %h", i, mem[16'h0500 + i], mdl[16'h0500 + i]);
            end
        end
    endtask

    task automatic test_addr_wrap;
        int cd, cr, hc;
        hlda = 1'b1;
        push_exp(16'hFFFE, 16'h0100, 3, 3);
        do_start(16'hFFFE, 16'h0100, 8'd3);
        run_to_done(cd, cr, hc);
        checks++;
        if (cd != 11 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
            errors++; $display("FAIL wrap_complete: done_cycle=%0d pending rd=%0d wr=%0d, required 11 and 0/0",
                               cd, exp_rd.size(), exp_wr.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[16'h0100 + i] !== mdl[16'h0100 + i]) begin
                errors++; $display("FAIL wrap_data[%0d]: got %h, required %h", i, mem[16'h0100 + i], mdl[16'h0100 + i]);
            end
        end
    endtask

    task automatic test_reset_abort;
        int cd, cr, hc, nr;
        hlda = 1'b1;
        push_exp(16'h0600, 16'h0700, 2, 1);
        do_start(16'h0600, 16'h0700, 8'd4);
        nr = 0;
        for (int c = 0; c < 50; c++) begin
            if (read) nr++;
            if (nr == 2) break;
            @(negedge clk);
        end
        @(negedge clk);           // LAT of byte 2
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({hold, busy, read, write} !== 4'b0 || cnt !== 8'd0) begin
            errors++; $display("FAIL abort_state: hold/busy/rd/wr=%b cnt=%0d, required 0000 cnt=0",
                               {hold, busy, read, write}, cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem[16'h0700] !== mdl[16'h0700] || mem[16'h0701] !== mdl[16'h0701] || exp_wr.size() != 0) begin
            errors++; $display("FAIL abort_dest: got %h %h, required %h %h", mem[16'h0700], mem[16'h0701],
                               mdl[16'h0700], mdl[16'h0701]);
        end
        push_exp(16'h0610, 16'h0710, 2, 2);
        do_start(16'h0610, 16'h0710, 8'd2);
        run_to_done(cd, cr, hc);
        checks++;
        if (cd != 8 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
            errors++; $display("FAIL abort_restart: done_cycle=%0d pending rd=%0d wr=%0d, required 8 and 0/0",
                               cd, exp_rd.size(), exp_wr.size());
        end
    endtask

    task automatic test_back_to_back;
        int cd, cr, hc, d0;
        hlda = 1'b1;
        d0 = done_cnt;
        push_exp(16'h0800, 16'h0900, 3, 3);
        do_start(16'h0800, 16'h0900, 8'd3);
        @(negedge clk);           // cycle 2: busy, pulse a second start
        src_addr = 16'h0A00; dst_addr = 16'h0B00; len = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_to_done(cd, cr, hc);  // counting from cycle 3
        repeat (5) @(negedge clk);
        checks++;
        if (cd != 9 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL busy_start: done_cycle=%0d done_pulses=%0d, required 9 and 1", cd, done_cnt - d0);
        end
        checks++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL busy_start_drain: pending rd=%0d wr=%0d busy=%b, required 0/0/0",
                               exp_rd.size(), exp_wr.size(), busy);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[16'h0900 + i] !== mdl[16'h0900 + i]) begin
                errors++; $display("FAIL busy_start_data[%0d]: got %h, required %h", i, mem[16'h0900 + i], mdl[16'h0900 + i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = pat(i);
            mdl[i] = pat(i);
        end
        data_in = 8'h00;
        rst = 1'b1; start = 1'b0; hlda = 1'b1;
        src_addr = '0; dst_addr = '0; len = '0;
        @(negedge clk);
        test_reset;
        test_basic_copy;
        test_len_zero;
        test_grant_control;
        test_addr_wrap;
        test_reset_abort;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
